rd_req_sequencer: RTL and testbench
===================================

Name: rd_req_sequencer

Overview:
- Upstream feeder for the two-process read-control FSM (go `g0`, wait-state `ws` in; read strobe `rd`, done `ds` out).
- Buffers incoming read requests in a small FIFO and issues one `g0` pulse per request.
- Drives `ws` to insert a programmable number of wait loops per access.
- Retires the request on `ds` and emits a one-cycle completion carrying the address.

Parameters:
- ADDR_W, 8: request/memory address width.
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- WAIT_W, 3: width of the wait-count configuration.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request offered.
- req_addr  in  ADDR_W  request address.
- req_ready  out  1  FIFO can accept; equals not-full.
- wait_cfg  in  WAIT_W  wait loops per access; sampled at issue.
- g0  out  1  go pulse to the read-control FSM.
- ws  out  1  wait-state request to the read-control FSM.
- rd  in  1  read strobe from the read-control FSM.
- ds  in  1  done strobe from the read-control FSM.
- mem_addr  out  ADDR_W  address of the in-flight access (FIFO head).
- cmp_valid  out  1  completion pulse, one cycle.
- cmp_addr  out  ADDR_W  address of the completed access.
- busy  out  1  high when the FIFO is non-empty or state is not IDLE.
- err  out  1  sticky protocol error.

Behaviour:
- Reset is asynchronous and active-high.
  - Clears FIFO pointers and count, state=IDLE, phase=0, wait_cnt=0.
  - All outputs 0; mem_addr and cmp_addr 0.
  - Reset mid-access discards the FIFO contents; no completion is emitted.
- FIFO:
  - Push on req_valid&&req_ready.
  - Pop on the cycle ds=1 while state=ACTIVE.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - No push when full; no pop when empty.
- Sequencer states:
  - IDLE: go to ISSUE if FIFO non-empty.
  - ISSUE: g0=1 for exactly this cycle. Latch wait_cnt<=wait_cfg and phase<=0. Next state ACTIVE.
  - ACTIVE: phase tracks the controller's alternating read sub-states (phase 0 = first read cycle, phase 1 = wait-decision cycle). Phase toggles each cycle rd=1.
  - ws = ACTIVE && wait_cnt!=0 (level; only meaningful in phase 1).
  - On phase 1 with wait_cnt!=0, decrement wait_cnt.
  - ds=1: pop, then on the next cycle cmp_valid=1 with cmp_addr = popped address. State goes to IDLE.
- mem_addr equals the FIFO head. It is stable from ISSUE through the ds cycle.
- Timing, request pushed in cycle 0 into an empty FIFO, wait_cfg=N:
  - cycle 1 IDLE; cycle 2 g0=1.
  - cycles 3 .. 2N+4: rd=1 (2(N+1) cycles).
  - cycle 2N+5: ds=1.
  - cycle 2N+6: cmp_valid=1.
- Back-to-back: after a completion, the next g0 comes 2 cycles after ds (IDLE, then ISSUE).
- err is set (sticky until reset) on any of:
  - ds=1 while state!=ACTIVE;
  - rd=1 while state is IDLE or ISSUE;
  - rd=0 and ds=0 while ACTIVE.
- err does not alter sequencing.
- wait_cfg changes during ACTIVE have no effect on the in-flight access.
- wait_cfg at its maximum (2^WAIT_W−1) must work with no counter overflow.

Decomposition:
- Package rd_seq_pkg:
  - sequencer state encoding IDLE=2'b00, ISSUE=2'b01, ACTIVE=2'b10 (2'b11 unused and recovers to IDLE);
  - phase constants PH_FIRST=0, PH_DECIDE=1.
- Sub-module rd_req_fifo (parameters ADDR_W, DEPTH):
  - ports push, push_data, pop, head, full, empty, count;
  - asynchronous active-high reset.
- Top level holds the sequencer, the wait counter, completion register and error logic.

Test Plan:
- Single request addr 0x5A, wait_cfg=0, bench models the read-control FSM -> g0 cycle 2, rd cycles 3-4, ds cycle 5, cmp_valid cycle 6 with cmp_addr=0x5A, ws never 1 in phase 1.
- wait_cfg=2, addr 0x11 -> ws=1 on the first two phase-1 cycles, 0 on the third; rd high 6 cycles; cmp_addr=0x11.
- Push 5 requests 0x01-0x05 back-to-back at DEPTH=4 -> req_ready drops after 4 accepted; 0x05 accepted after the first pop; completions in order 0x01..0x05.
- Simultaneous push of 0x22 on the ds cycle of 0x21 with count=1 -> count stays 1; next g0 2 cycles later; mem_addr=0x22.
- Assert rst mid-access (during rd) with 3 queued -> all outputs 0 immediately; no cmp_valid; busy=0 after release.
- Inject ds=1 in IDLE -> err=1 and remains 1; a following normal request still completes correctly.

Source files
------------

// File: rtl/rd_seq_pkg.sv
// rd_seq_pkg: shared definitions for the read-request sequencer.
//   seq_state_e : sequencer state encoding. 2'b11 is unused and falls back to idle.
//   PH_FIRST    : phase of the controller's first read cycle.
//   PH_DECIDE   : phase of the controller's wait-decision cycle.
package rd_seq_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StIssue  = 2'b01,
        StActive = 2'b10
    } seq_state_e;

    localparam logic PH_FIRST  = 1'b0;
    localparam logic PH_DECIDE = 1'b1;

endpackage

// File: rtl/rd_req_sequencer_if.sv
// rd_req_sequencer_if: request, read-controller and completion signals of the sequencer.
//   req_valid/req_addr/req_ready : request handshake into the FIFO
//   wait_cfg                     : wait loops per access, sampled at issue
//   g0/ws                        : go pulse and wait-state request to the read controller
//   rd/ds                        : read and done strobes from the read controller
//   mem_addr                     : address of the in-flight access
//   cmp_valid/cmp_addr           : one-cycle completion with its address
//   busy/err                     : activity flag and sticky protocol error
// Modport slave is the sequencer side; master is its environment.
interface rd_req_sequencer_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WAIT_W = 3
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic [WAIT_W-1:0] wait_cfg;
    logic              g0;
    logic              ws;
    logic              rd;
    logic              ds;
    logic [ADDR_W-1:0] mem_addr;
    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic              busy;
    logic              err;

    modport slave (
        input  req_valid, req_addr, wait_cfg, rd, ds,
        output req_ready, g0, ws, mem_addr, cmp_valid, cmp_addr, busy, err
    );

    modport master (
        output req_valid, req_addr, wait_cfg, rd, ds,
        input  req_ready, g0, ws, mem_addr, cmp_valid, cmp_addr, busy, err
    );
endinterface

// File: rtl/rd_req_fifo.sv
// rd_req_fifo: small address FIFO feeding the sequencer.
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : write i_push_data (ignored when full)
//   i_pop        : drop the head entry (ignored when empty)
//   o_head       : entry at the read pointer
//   o_full/o_empty/o_count : occupancy
module rd_req_fifo #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage is cleared too so the head (and mem_addr) reads 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/rd_req_sequencer.sv
// rd_req_sequencer: buffers read requests and drives the read-control FSM one access
// at a time (g0 pulse, ws wait loops), retiring each access on ds with a completion.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rd_req_sequencer_if.slave (requests, controller strobes, completion, status)
module rd_req_sequencer
    import rd_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WAIT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    rd_req_sequencer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    seq_state_e        r_state;
    seq_state_e        w_state_d;
    logic              r_phase;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_cmp_valid;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic              r_err;

    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [ADDR_W-1:0] w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_err_evt;

    assign w_push = bus.req_valid && !w_full;
    assign w_pop  = (r_state == StActive) && bus.ds;

    rd_req_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (bus.req_addr),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:   if (!w_empty) w_state_d = StIssue;
            StIssue:  w_state_d = StActive;
            StActive: if (bus.ds) w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Protocol violations by the read controller; recorded only, sequencing is unaffected.
    assign w_err_evt = (bus.ds && (r_state != StActive))
                    || (bus.rd && ((r_state == StIdle) || (r_state == StIssue)))
                    || (!bus.rd && !bus.ds && (r_state == StActive));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= PH_FIRST;
            r_wait_cnt  <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_addr  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == StIssue) begin
                r_wait_cnt <= bus.wait_cfg;
                r_phase    <= PH_FIRST;
            end else if ((r_state == StActive) && bus.rd) begin
                // Phase follows the controller only on real read cycles, so a stall
                // cannot consume a wait loop.
                r_phase <= (r_phase == PH_FIRST) ? PH_DECIDE : PH_FIRST;
                if ((r_phase == PH_DECIDE) && (r_wait_cnt != '0)) begin
                    r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                end
            end
            r_cmp_valid <= w_pop;
            if (w_pop) begin
                r_cmp_addr <= w_head;
            end
            r_err <= r_err || w_err_evt;
        end
    end

    // req_ready is held low while reset is asserted so every output reads 0 in reset.
    assign bus.req_ready = !w_full && !rst;
    assign bus.g0        = (r_state == StIssue);
    assign bus.ws        = (r_state == StActive) && (r_wait_cnt != '0);
    assign bus.mem_addr  = w_head;
    assign bus.cmp_valid = r_cmp_valid;
    assign bus.cmp_addr  = r_cmp_addr;
    assign bus.busy      = (w_count != '0) || (r_state != StIdle);
    assign bus.err       = r_err;

endmodule

// File: tb/tb_rd_req_sequencer.sv
module tb_rd_req_sequencer;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned WAIT_W = 3;
    localparam int BIG = 32'h3fff_ffff;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rd_req_sequencer_if #(.ADDR_W(ADDR_W), .WAIT_W(WAIT_W)) bus ();

    rd_req_sequencer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .WAIT_W (WAIT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue contents plus the spec's timing arithmetic per access.
    logic [7:0] q[$];
    logic [7:0] pend[$];
    int         c = 0;
    int         m_g0, m_ds, m_n, m_free, m_cmp_cyc;
    logic [7:0] m_cmp_addr;
    bit         m_active, m_err;
    // Bench read-control FSM: 0 idle, 1 first read, 2 decide, 3 done.
    int         cst;
    bit         rand_wc;
    logic [2:0] wc_fixed;
    bit         found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, c);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend.delete();
        m_active   = 1'b0;
        m_err      = 1'b0;
        m_g0       = -10;
        m_ds       = BIG;
        m_n        = 0;
        m_free     = c;
        m_cmp_cyc  = -10;
        m_cmp_addr = '0;
        cst        = 0;
    endtask

    task automatic run_cycle(input bit inj_ds);
        bit rd_v, ds_v, e_ready, e_g0, e_ws, e_cmp, win, g0_s, ws_s;
        rd_v = (cst == 1) || (cst == 2);
        ds_v = (cst == 3) || inj_ds;
        bus.rd        = rd_v;
        bus.ds        = ds_v;
        bus.req_valid = (pend.size() > 0);
        bus.req_addr  = (pend.size() > 0) ? pend[0] : 8'($urandom);
        bus.wait_cfg  = rand_wc ? 3'($urandom_range(0, 7)) : wc_fixed;
        #1;
        if (!m_active && c >= m_free && q.size() > 0) begin
            m_active = 1'b1;
            m_g0     = c + 1;
            m_ds     = BIG;
        end
        e_g0 = m_active && (c == m_g0);
        if (e_g0) begin
            m_n  = int'(bus.wait_cfg);
            m_ds = c + 2 * m_n + 3;
        end
        e_ws    = m_active && (c > m_g0) && (c <= m_ds) && ((m_n - (c - m_g0 - 1) / 2) > 0);
        e_ready = (q.size() < DEPTH);
        e_cmp   = (c == m_cmp_cyc);
        chk("g0", bus.g0, e_g0);
        chk("ws", bus.ws, e_ws);
        chk("req_ready", bus.req_ready, e_ready);
        chk("busy", bus.busy, (q.size() > 0) || m_active);
        chk("cmp_valid", bus.cmp_valid, e_cmp);
        chk("err", bus.err, m_err);
        if (e_cmp) chk("cmp_addr", bus.cmp_addr, m_cmp_addr);
        if (m_active && c >= m_g0 && c <= m_ds) chk("mem_addr", bus.mem_addr, q[0]);
        g0_s = bus.g0;
        ws_s = bus.ws;
        win  = m_active && (c > m_g0) && (c <= m_ds);
        if (((rd_v || ds_v) && !win) || (win && !rd_v && !ds_v)) m_err = 1'b1;
        if (m_active && c == m_ds) begin
            m_cmp_addr = q.pop_front();
            m_cmp_cyc  = c + 1;
            m_active   = 1'b0;
            m_free     = c + 1;
            m_ds       = BIG;
        end
        if (bus.req_valid && e_ready) q.push_back(pend.pop_front());
        @(posedge clk);
        #1;
        case (cst)
            0:       cst = g0_s ? 1 : 0;
            1:       cst = 2;
            2:       cst = ws_s ? 1 : 3;
            default: cst = 0;
        endcase
        c++;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (pend.size() == 0 && q.size() == 0 && !m_active && c > m_cmp_cyc) break;
            run_cycle(1'b0);
        end
        chk("drain_busy", bus.busy, 1'b0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.wait_cfg  = '0;
        bus.rd        = 1'b0;
        bus.ds        = 1'b0;
        rand_wc       = 1'b0;
        wc_fixed      = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_g0", bus.g0, 1'b0);
        chk("rst_ws", bus.ws, 1'b0);
        chk("rst_ready", bus.req_ready, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_cmp_valid", bus.cmp_valid, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 8'h00);
        chk("rst_cmp_addr", bus.cmp_addr, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Single access, no wait loops.
        wc_fixed = 3'd0;
        pend.push_back(8'h5A);
        drain();

        // Two wait loops.
        wc_fixed = 3'd2;
        pend.push_back(8'h11);
        drain();

        // Maximum wait count.
        wc_fixed = 3'd7;
        pend.push_back(8'hF0);
        drain();

        // Five back-to-back requests overflow a four-entry FIFO.
        wc_fixed = 3'd1;
        for (int i = 1; i <= 5; i++) pend.push_back(8'(i));
        drain();

        // Push on the ds cycle with one entry queued.
        wc_fixed = 3'd1;
        pend.push_back(8'h21);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_active && c == m_ds) begin
                found = 1'b1;
                break;
            end
            run_cycle(1'b0);
        end
        chk("ds_reached", found, 1'b1);
        pend.push_back(8'h22);
        run_cycle(1'b0);
        drain();

        // Random traffic with wait_cfg changing every cycle.
        rand_wc = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0 && pend.size() < 2) pend.push_back(8'($urandom));
            run_cycle(1'b0);
        end
        drain();
        rand_wc = 1'b0;

        // Reset during a read with three more requests queued.
        wc_fixed = 3'd3;
        for (int i = 0; i < 4; i++) pend.push_back(8'(8'h31 + i));
        for (int i = 0; i < 40; i++) begin
            if (m_active && c > m_g0 + 1 && pend.size() == 0) break;
            run_cycle(1'b0);
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_g0", bus.g0, 1'b0);
        chk("mid_rst_ws", bus.ws, 1'b0);
        chk("mid_rst_ready", bus.req_ready, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_cmp_valid", bus.cmp_valid, 1'b0);
        chk("mid_rst_mem_addr", bus.mem_addr, 8'h00);
        chk("mid_rst_cmp_addr", bus.cmp_addr, 8'h00);
        bus.rd        = 1'b0;
        bus.ds        = 1'b0;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) run_cycle(1'b0);

        // Stray ds while idle sets err; a later access still completes.
        run_cycle(1'b1);
        run_cycle(1'b0);
        chk("err_sticky", bus.err, 1'b1);
        wc_fixed = 3'd1;
        pend.push_back(8'h77);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
